slot_ramdisk_ctrl: RTL and testbench
====================================

# slot_ramdisk_ctrl

Parametrised multi-channel successor to the slot RAM-disk/ROM controller. Decodes Apple II slot selects, times RAM/ROM chip selects and data-bus drive from a C7M-based phase counter, and provides NCH independent auto-stepping address pointers into the card SRAM, each with its own step direction. It sits between the Apple II bus, the DS1215 gating path and the shared RAM/ROM address and data pins. The PHI1 hold-delay chain stays outside this block.

## Interface
- ADDR_W, 24: SRAM address width, 17..24; the pointer is held as three byte lanes L/M/H with unused H bits reading 0.
- NCH, 2: number of address-pointer channels, power of two, 1..8.
- BANK_W, 1: ROM bank register width, 1..4.
- C7M  in  1  7 MHz bus clock; the only clock, all state on rising edge.
- RES  in  1  synchronous active-high reset.
- PHI1  in  1  hold-delayed PHI1.
- A  in  16  6502 address bus.
- nWE  in  1  6502 R/W, 1 = read.
- nDEVSEL, nIOSEL, nIOSTRB  in  1 each  slot selects, active low.
- Din  in  8  Apple II data bus, input side.
- Dout  out  8  Apple II read data.
- DOE  out  1  Apple II bus drive enable.
- RDOE  out  1  RAM/ROM data-pin drive enable, writes only.
- RA  out  ADDR_W  RAM/ROM address.
- nRAMROMCS  out  1  select passed to DS1215.
- RAMROMCSgb  in  1  gated and inverted select back from DS1215.
- RAMCS  out  1  SRAM chip select.
- nROMCS  out  1  ROM chip select, active low.

## Operation
- Phase counter S (3 bits). On each edge, S ← 1 if PHI1 is high, PHI1 was low on the previous edge, and PHI0seen is set. Otherwise S holds at 0 and at 7, and increments in all other states. PHI0seen sets on the first edge with PHI1 low.
- DBEN ← S∈{4..7}. CSEN ← (S==4 & nWE) | S∈{5,6,7}.
- At S==4 with nIOSEL low: set REGEN and IOROMEN.
- At S==4 with nIOSTRB low and A[10:0]==7FF: clear IOROMEN.
- DEVSEL registers, gated by REGEN, decoded on A[3:0]:
  - 0, 1, 2: pointer L/M/H of the current channel, read/write.
  - 3: data port, which selects the SRAM at the current channel's pointer.
  - 4: CTRL. Bits[2:0] = current channel, masked to log2(NCH) bits. Bit 7 = step direction of the current channel (0 = +1, 1 = −1). Reads return the stored values.
  - 5, 6: transfer counter lo/hi (see Configuration).
  - F: ROM bank, write-only.
  - All other offsets read 00.
- Register writes take effect at the S==6 edge using Din.
- A data-port access at S==6 sets a step-pending flag and latches the channel.
- At the next S==2 edge, the latched channel's pointer gets ±1 as a full ADDR_W-bit add, wrapping modulo 2^ADDR_W. The flag then clears.
- RA: during nIOSEL or nIOSTRB low, RA = {zeros, bank, A[10:0]}. Otherwise RA = the current channel's pointer.
- RAMCS = data-port select & CSEN.
- nROMCS = ~(CSEN & ((~nIOSEL & RAMROMCSgb) | (~nIOSTRB & IOROMEN))).
- nRAMROMCS = ~(data-port select | ~nIOSEL).
- RDOE = DBEN & ~nWE.
- DOE = DBEN & nWE & (register read | data-port read & RAMROMCSgb | ~nIOSEL & RAMROMCSgb | ~nIOSTRB & IOROMEN).

## Timing
- Reset values:
  - S = 0, PHI0seen = 0.
  - DBEN, CSEN, REGEN, IOROMEN, step-pending = 0.
  - All pointers = 0, all directions = 0 (increment), current channel = 0, bank = 0, counters = 0.
  - Outputs: DOE = 0, RDOE = 0, RAMCS = 0, nROMCS = 1. nRAMROMCS follows nIOSEL.
- Reset mid-cycle abandons any pending step. The counter re-synchronises only after PHI1 has been seen low and then rises.
- Step latency: the pointer changes at the S==2 edge of the next bus cycle, while CSEN is already 0. A back-to-back data access therefore sees the stepped address.
- A write to a pointer byte at S==6 in the same cycle as a data access: the byte write lands at S==6 and the step is applied to the written value at the next S==2.
- A CTRL channel change does not redirect a step that is already pending.

## Configuration
- SLOT_XFER_COUNT_EN defined:
  - Each channel has a 16-bit down-counter at offsets 5/6.
  - Each data-port access decrements the current channel's counter, saturating at 0.
  - CTRL bit 6 reads 1 when the current channel's counter is 0.
- SLOT_XFER_COUNT_EN undefined: offsets 5/6 read 00 and ignore writes; CTRL bit 6 reads 0.

## Structure
- Package slot_pkg holds the register-offset constants (0–6, F), phase state values S1–S7, and CTRL bit positions.
- One sub-module, slot_ptr_chan, holds one channel's pointer, direction, optional counter and ±1 stepper. It is instantiated NCH times.

## Test plan
- Reset, then 3 PHI1 periods: S follows 1..7 each period; DOE, CSEN and nROMCS stay idle without selects.
- Write L=FF, M=FF, H=00 on ch0, direction +1, then read the data port → at the next S2 the pointer reads 01_0000. Repeat with direction −1 from 000000 → wraps to 2^ADDR_W−1.
- Set CTRL ch=1 and load pointer 000100, then switch to ch0 → ch0 pointer is unchanged; RA follows the selected channel.
- Data access on ch1 followed by a CTRL write selecting ch0 in the next cycle → ch1 steps and ch0 does not.
- IOSEL access → IOROMEN=1. IOSTRB access at CFFF → IOROMEN=0, nROMCS stays high on a subsequent IOSTRB access.
- With SLOT_XFER_COUNT_EN: counter=0002, three data accesses → counter 0000 and CTRL bit 6 = 1.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared constants for the slot RAM-disk/ROM controller: register offsets,
// bus-phase values and CTRL register bit positions.
package slot_pkg;

  localparam logic [3:0] REG_PTR_L = 4'h0;
  localparam logic [3:0] REG_PTR_M = 4'h1;
  localparam logic [3:0] REG_PTR_H = 4'h2;
  localparam logic [3:0] REG_DATA  = 4'h3;
  localparam logic [3:0] REG_CTRL  = 4'h4;
  localparam logic [3:0] REG_CNT_L = 4'h5;
  localparam logic [3:0] REG_CNT_H = 4'h6;
  localparam logic [3:0] REG_BANK  = 4'hF;

  // S0 is the idle/unsynchronised phase; S1..S7 walk one bus cycle.
  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [2:0] S6 = 3'd6;
  localparam logic [2:0] S7 = 3'd7;

  localparam int CTRL_DIR_BIT  = 7;
  localparam int CTRL_ZERO_BIT = 6;
  localparam int CTRL_CH_W     = 3;

endpackage

// File: rtl/slot_ptr_chan.sv
// One auto-stepping SRAM address pointer channel: byte-lane pointer, step
// direction, +/-1 stepper and (with SLOT_XFER_COUNT_EN) a transfer down-counter.
module slot_ptr_chan
  import slot_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        din_i,
  input  logic              we_l_i,
  input  logic              we_m_i,
  input  logic              we_h_i,
  input  logic              we_dir_i,
  input  logic              we_cl_i,
  input  logic              we_ch_i,
  input  logic              dec_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              dir_o,
  output logic [15:0]       cnt_o
);

  localparam int HI_W = ADDR_W - 16;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              dir_q, dir_d;

  always_comb begin
    ptr_d = ptr_q;
    dir_d = dir_q;
    if (we_l_i)   ptr_d[7:0]         = din_i;
    if (we_m_i)   ptr_d[15:8]        = din_i;
    if (we_h_i)   ptr_d[ADDR_W-1:16] = din_i[HI_W-1:0];
    if (we_dir_i) dir_d              = din_i[CTRL_DIR_BIT];
    // Adding all-ones is the -1 step; both directions wrap modulo 2^ADDR_W.
    if (step_i)   ptr_d = ptr_q + (dir_q ? {ADDR_W{1'b1}} : ADDR_W'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      dir_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      dir_q <= dir_d;
    end
  end

  assign ptr_o = ptr_q;
  assign dir_o = dir_q;

`ifdef SLOT_XFER_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_cl_i) cnt_d[7:0]  = din_i;
    if (we_ch_i) cnt_d[15:8] = din_i;
    if (dec_i && (cnt_q != 16'd0)) cnt_d = cnt_q - 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  logic unused_cnt_ctl;
  assign unused_cnt_ctl = we_cl_i ^ we_ch_i ^ dec_i;
  assign cnt_o          = 16'd0;
`endif

endmodule

// File: rtl/slot_ramdisk_ctrl.sv
// Apple II slot RAM-disk/ROM controller with NCH stepping SRAM pointers.
// Optional transfer counters are built when SLOT_XFER_COUNT_EN is defined.
module slot_ramdisk_ctrl
  import slot_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int NCH    = 2,
  parameter int BANK_W = 1
) (
  input  logic              C7M,
  input  logic              RES,
  input  logic              PHI1,
  input  logic [15:0]       A,
  input  logic              nWE,
  input  logic              nDEVSEL,
  input  logic              nIOSEL,
  input  logic              nIOSTRB,
  input  logic [7:0]        Din,
  output logic [7:0]        Dout,
  output logic              DOE,
  output logic              RDOE,
  output logic [ADDR_W-1:0] RA,
  output logic              nRAMROMCS,
  input  logic              RAMROMCSgb,
  output logic              RAMCS,
  output logic              nROMCS
);

  localparam int CH_BITS = (NCH > 1) ? $clog2(NCH) : 0;
  localparam int CH_W    = (CH_BITS > 0) ? CH_BITS : 1;
  localparam logic [CH_W-1:0] CH_MASK = CH_W'(NCH - 1);

  logic [2:0]        s_q, s_d;
  logic              phi1_last_q, phi0seen_q, phi0seen_d;
  logic              dben_q, dben_d, csen_q, csen_d;
  logic              regen_q, regen_d, ioromen_q, ioromen_d;
  logic              pend_q, pend_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d, ch_q, ch_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  logic              iosel, iostrb, reg_sel, data_sel, reg_wr, ctrl_wr, data_acc, step_now;
  logic [CH_W-1:0]   new_ch;
  logic [ADDR_W-1:0] ptr_a [NCH];
  logic              dir_a [NCH];
  logic [15:0]       cnt_a [NCH];
  logic [ADDR_W-1:0] cur_ptr;
  logic [23:0]       cur_ptr24;
  logic [15:0]       cur_cnt;
  logic              cur_zero;
  logic              unused_addr;

  assign unused_addr = ^A[15:11];

  assign iosel    = ~nIOSEL;
  assign iostrb   = ~nIOSTRB;
  assign reg_sel  = ~nDEVSEL & regen_q;
  assign data_sel = reg_sel & (A[3:0] == REG_DATA);
  assign reg_wr   = reg_sel & ~nWE & (s_q == S6);
  assign ctrl_wr  = reg_wr & (A[3:0] == REG_CTRL);
  assign data_acc = data_sel & (s_q == S6);
  assign step_now = pend_q & (s_q == S2);
  assign new_ch   = Din[CH_W-1:0] & CH_MASK;

  always_comb begin
    s_d        = s_q + 3'd1;
    if (PHI1 && !phi1_last_q && phi0seen_q) s_d = S1;
    else if ((s_q == S0) || (s_q == S7))    s_d = s_q;
    phi0seen_d = phi0seen_q | ~PHI1;
    dben_d     = (s_q >= S4);
    csen_d     = ((s_q == S4) & nWE) | (s_q >= S5);
    regen_d    = regen_q;
    ioromen_d  = ioromen_q;
    if ((s_q == S4) && iosel) begin
      regen_d   = 1'b1;
      ioromen_d = 1'b1;
    end else if ((s_q == S4) && iostrb && (A[10:0] == 11'h7FF)) begin
      ioromen_d = 1'b0;
    end
    // The step target is latched at the access so a later CTRL write cannot redirect it.
    pend_d    = pend_q;
    pend_ch_d = pend_ch_q;
    if (data_acc) begin
      pend_d    = 1'b1;
      pend_ch_d = ch_q;
    end else if (s_q == S2) begin
      pend_d = 1'b0;
    end
    ch_d   = ctrl_wr ? new_ch : ch_q;
    bank_d = (reg_wr && (A[3:0] == REG_BANK)) ? Din[BANK_W-1:0] : bank_q;
  end

  always_ff @(posedge C7M) begin
    if (RES) begin
      s_q         <= S0;
      phi1_last_q <= 1'b0;
      phi0seen_q  <= 1'b0;
      dben_q      <= 1'b0;
      csen_q      <= 1'b0;
      regen_q     <= 1'b0;
      ioromen_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      ch_q        <= '0;
      bank_q      <= '0;
    end else begin
      s_q         <= s_d;
      phi1_last_q <= PHI1;
      phi0seen_q  <= phi0seen_d;
      dben_q      <= dben_d;
      csen_q      <= csen_d;
      regen_q     <= regen_d;
      ioromen_q   <= ioromen_d;
      pend_q      <= pend_d;
      pend_ch_q   <= pend_ch_d;
      ch_q        <= ch_d;
      bank_q      <= bank_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic own;
    assign own = (ch_q == CH_W'(i));
    slot_ptr_chan #(.ADDR_W(ADDR_W)) u_chan (
      .clk_i    (C7M),
      .rst_i    (RES),
      .din_i    (Din),
      .we_l_i   (reg_wr & own & (A[3:0] == REG_PTR_L)),
      .we_m_i   (reg_wr & own & (A[3:0] == REG_PTR_M)),
      .we_h_i   (reg_wr & own & (A[3:0] == REG_PTR_H)),
      .we_dir_i (ctrl_wr & (new_ch == CH_W'(i))),
      .we_cl_i  (reg_wr & own & (A[3:0] == REG_CNT_L)),
      .we_ch_i  (reg_wr & own & (A[3:0] == REG_CNT_H)),
      .dec_i    (data_acc & own),
      .step_i   (step_now & (pend_ch_q == CH_W'(i))),
      .ptr_o    (ptr_a[i]),
      .dir_o    (dir_a[i]),
      .cnt_o    (cnt_a[i])
    );
  end

  assign cur_ptr   = ptr_a[ch_q];
  assign cur_ptr24 = 24'(cur_ptr);
  assign cur_cnt   = cnt_a[ch_q];
`ifdef SLOT_XFER_COUNT_EN
  assign cur_zero  = (cur_cnt == 16'd0);
`else
  assign cur_zero  = 1'b0;
`endif

  always_comb begin
    Dout = 8'h00;
    case (A[3:0])
      REG_PTR_L: Dout = cur_ptr24[7:0];
      REG_PTR_M: Dout = cur_ptr24[15:8];
      REG_PTR_H: Dout = cur_ptr24[23:16];
      REG_CTRL: begin
        Dout[CTRL_CH_W-1:0]  = CTRL_CH_W'(ch_q);
        Dout[CTRL_ZERO_BIT]  = cur_zero;
        Dout[CTRL_DIR_BIT]   = dir_a[ch_q];
      end
      REG_CNT_L: Dout = cur_cnt[7:0];
      REG_CNT_H: Dout = cur_cnt[15:8];
      default:   Dout = 8'h00;
    endcase
  end

  always_comb begin
    RA = cur_ptr;
    if (iosel || iostrb) begin
      RA               = '0;
      RA[10:0]         = A[10:0];
      RA[11 +: BANK_W] = bank_q;
    end
  end

  assign RAMCS     = data_sel & csen_q;
  assign nROMCS    = ~(csen_q & ((iosel & RAMROMCSgb) | (iostrb & ioromen_q)));
  assign nRAMROMCS = ~(data_sel | iosel);
  assign RDOE      = dben_q & ~nWE;
  assign DOE       = dben_q & nWE & ((reg_sel & ~data_sel) | (data_sel & RAMROMCSgb) |
                                     (iosel & RAMROMCSgb) | (iostrb & ioromen_q));

endmodule

// File: tb/tb_slot_ramdisk_ctrl.sv
// Directed bench for slot_ramdisk_ctrl: bus cycles of eight C7M edges with
// PHI1 high for four, outputs sampled 1 ns after each rising edge.
module tb_slot_ramdisk_ctrl;

  logic        C7M = 1'b0;
  logic        RES = 1'b1;
  logic        PHI1 = 1'b0;
  logic [15:0] A = 16'h0000;
  logic        nWE = 1'b1, nDEVSEL = 1'b1, nIOSEL = 1'b1, nIOSTRB = 1'b1;
  logic [7:0]  Din = 8'h00;
  logic        RAMROMCSgb = 1'b1;
  logic [7:0]  Dout;
  logic        DOE, RDOE, nRAMROMCS, RAMCS, nROMCS;
  logic [23:0] RA;

  int checks = 0;
  int errors = 0;

  logic [2:0]  s_seen     [1:8];
  logic        doe_seen   [1:8];
  logic        rdoe_seen  [1:8];
  logic        ramcs_seen [1:8];
  logic        nrom_seen  [1:8];
  logic        nrc_seen   [1:8];
  logic [23:0] ra_seen    [1:8];
  logic [7:0]  dout_seen  [1:8];

  localparam logic [15:0] DEV = 16'hC0E0;
`ifdef SLOT_XFER_COUNT_EN
  localparam logic [7:0] ZBIT = 8'h40;
  localparam bit XFER = 1'b1;
`else
  localparam logic [7:0] ZBIT = 8'h00;
  localparam bit XFER = 1'b0;
`endif

  slot_ramdisk_ctrl dut (
    .C7M(C7M), .RES(RES), .PHI1(PHI1), .A(A), .nWE(nWE),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB), .Din(Din),
    .Dout(Dout), .DOE(DOE), .RDOE(RDOE), .RA(RA), .nRAMROMCS(nRAMROMCS),
    .RAMROMCSgb(RAMROMCSgb), .RAMCS(RAMCS), .nROMCS(nROMCS)
  );

  always #5 C7M = ~C7M;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_cycle(input logic [15:0] addr, input logic rd, input logic devsel_n,
                           input logic iosel_n, input logic iostrb_n, input logic [7:0] din);
    for (int k = 1; k <= 8; k++) begin
      @(negedge C7M);
      if (k == 1) begin
        A = addr; nWE = rd; nDEVSEL = devsel_n; nIOSEL = iosel_n; nIOSTRB = iostrb_n; Din = din;
      end
      PHI1 = (k <= 4);
      @(posedge C7M);
      #1;
      s_seen[k] = dut.s_q; doe_seen[k] = DOE; rdoe_seen[k] = RDOE; ramcs_seen[k] = RAMCS;
      nrom_seen[k] = nROMCS; nrc_seen[k] = nRAMROMCS; ra_seen[k] = RA; dout_seen[k] = Dout;
    end
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [7:0] d);
    bus_cycle(DEV | 16'(off), 1'b0, 1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic reg_rd(input logic [3:0] off);
    bus_cycle(DEV | 16'(off), 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic idle();
    bus_cycle(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic test_reset();
    RES = 1'b1; PHI1 = 1'b0;
    repeat (3) @(posedge C7M);
    #1;
    checks++; if (DOE !== 1'b0) begin errors++; $display("FAIL reset_doe: got %b exp 0", DOE); end
    checks++; if (RDOE !== 1'b0) begin errors++; $display("FAIL reset_rdoe: got %b exp 0", RDOE); end
    checks++; if (RAMCS !== 1'b0) begin errors++; $display("FAIL reset_ramcs: got %b exp 0", RAMCS); end
    checks++; if (nROMCS !== 1'b1) begin errors++; $display("FAIL reset_nromcs: got %b exp 1", nROMCS); end
    checks++; if (nRAMROMCS !== 1'b1) begin errors++; $display("FAIL reset_nrc_hi: got %b exp 1", nRAMROMCS); end
    checks++; if (RA !== 24'h000000) begin errors++; $display("FAIL reset_ra: got %h exp 000000", RA); end
    checks++; if (dut.s_q !== 3'd0) begin errors++; $display("FAIL reset_s: got %0d exp 0", dut.s_q); end
    @(negedge C7M); nIOSEL = 1'b0; #1;
    checks++; if (nRAMROMCS !== 1'b0) begin errors++; $display("FAIL reset_nrc_lo: got %b exp 0", nRAMROMCS); end
    nIOSEL = 1'b1;
    @(negedge C7M); RES = 1'b0; PHI1 = 1'b0;
    repeat (2) @(posedge C7M);
  endtask

  task automatic test_phase();
    for (int c = 0; c < 3; c++) begin
      idle();
      for (int k = 1; k <= 8; k++) begin
        checks++;
        if (s_seen[k] !== 3'((k < 8) ? k : 7))
          begin errors++; $display("FAIL phase_s c%0d k%0d: got %0d exp %0d", c, k, s_seen[k], (k < 8) ? k : 7); end
        checks++;
        if (doe_seen[k] !== 1'b0 || ramcs_seen[k] !== 1'b0 || nrom_seen[k] !== 1'b1)
          begin errors++; $display("FAIL phase_idle c%0d k%0d: doe=%b ramcs=%b nrom=%b exp 0 0 1", c, k, doe_seen[k], ramcs_seen[k], nrom_seen[k]); end
      end
    end
  endtask

  task automatic test_iorom();
    bus_cycle(16'hC600, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    checks++; if (nrom_seen[6] !== 1'b0) begin errors++; $display("FAIL iosel_nrom: got %b exp 0", nrom_seen[6]); end
    checks++; if (doe_seen[6] !== 1'b1) begin errors++; $display("FAIL iosel_doe: got %b exp 1", doe_seen[6]); end
    checks++; if (ra_seen[6] !== 24'h000600) begin errors++; $display("FAIL iosel_ra: got %h exp 000600", ra_seen[6]); end
    checks++; if (nrc_seen[6] !== 1'b0) begin errors++; $display("FAIL iosel_nrc: got %b exp 0", nrc_seen[6]); end
    bus_cycle(16'hCA55, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++; if (nrom_seen[6] !== 1'b0) begin errors++; $display("FAIL iostrb_on_nrom: got %b exp 0", nrom_seen[6]); end
    checks++; if (ra_seen[6] !== 24'h000255) begin errors++; $display("FAIL iostrb_ra: got %h exp 000255", ra_seen[6]); end
    bus_cycle(16'hCFFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++; if (nrom_seen[6] !== 1'b1) begin errors++; $display("FAIL cfff_nrom: got %b exp 1", nrom_seen[6]); end
    bus_cycle(16'hCA55, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++; if (nrom_seen[6] !== 1'b1) begin errors++; $display("FAIL iostrb_off_nrom: got %b exp 1", nrom_seen[6]); end
    checks++; if (doe_seen[6] !== 1'b0) begin errors++; $display("FAIL iostrb_off_doe: got %b exp 0", doe_seen[6]); end
  endtask

  task automatic test_bank();
    reg_wr(4'hF, 8'h01);
    bus_cycle(16'hC6AB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    checks++; if (ra_seen[6] !== 24'h000EAB) begin errors++; $display("FAIL bank_ra: got %h exp 000EAB", ra_seen[6]); end
    reg_rd(4'hF);
    checks++; if (dout_seen[6] !== 8'h00) begin errors++; $display("FAIL bank_read: got %h exp 00", dout_seen[6]); end
    checks++; if (doe_seen[6] !== 1'b1) begin errors++; $display("FAIL reg_read_doe: got %b exp 1", doe_seen[6]); end
    reg_rd(4'h7);
    checks++; if (dout_seen[6] !== 8'h00) begin errors++; $display("FAIL off7_read: got %h exp 00", dout_seen[6]); end
  endtask

  task automatic test_step_inc();
    reg_wr(4'h4, 8'h00); reg_wr(4'h0, 8'hFF); reg_wr(4'h1, 8'hFF); reg_wr(4'h2, 8'h00);
    bus_cycle(DEV | 16'h3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (ra_seen[6] !== 24'h00FFFF) begin errors++; $display("FAIL inc_ra_access: got %h exp 00FFFF", ra_seen[6]); end
    checks++; if (ramcs_seen[6] !== 1'b1) begin errors++; $display("FAIL inc_ramcs: got %b exp 1", ramcs_seen[6]); end
    checks++; if (ramcs_seen[4] !== 1'b0) begin errors++; $display("FAIL inc_ramcs_early: got %b exp 0", ramcs_seen[4]); end
    checks++; if (nrc_seen[6] !== 1'b0) begin errors++; $display("FAIL inc_nrc: got %b exp 0", nrc_seen[6]); end
    idle();
    checks++; if (ra_seen[2] !== 24'h00FFFF) begin errors++; $display("FAIL inc_before_s2: got %h exp 00FFFF", ra_seen[2]); end
    checks++; if (ra_seen[3] !== 24'h010000) begin errors++; $display("FAIL inc_after_s2: got %h exp 010000", ra_seen[3]); end
    reg_rd(4'h2);
    checks++; if (dout_seen[6] !== 8'h01) begin errors++; $display("FAIL inc_read_h: got %h exp 01", dout_seen[6]); end
    reg_rd(4'h0);
    checks++; if (dout_seen[6] !== 8'h00) begin errors++; $display("FAIL inc_read_l: got %h exp 00", dout_seen[6]); end
  endtask

  task automatic test_step_dec();
    reg_wr(4'h4, 8'h80); reg_wr(4'h0, 8'h00); reg_wr(4'h1, 8'h00); reg_wr(4'h2, 8'h00);
    bus_cycle(DEV | 16'h3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
    checks++; if (rdoe_seen[6] !== 1'b1) begin errors++; $display("FAIL dec_rdoe: got %b exp 1", rdoe_seen[6]); end
    checks++; if (ramcs_seen[6] !== 1'b1) begin errors++; $display("FAIL dec_ramcs: got %b exp 1", ramcs_seen[6]); end
    checks++; if (doe_seen[6] !== 1'b0) begin errors++; $display("FAIL dec_doe: got %b exp 0", doe_seen[6]); end
    idle();
    checks++; if (ra_seen[3] !== 24'hFFFFFF) begin errors++; $display("FAIL dec_wrap: got %h exp FFFFFF", ra_seen[3]); end
    reg_rd(4'h4);
    checks++; if (dout_seen[6] !== (8'h80 | ZBIT)) begin errors++; $display("FAIL dec_ctrl: got %h exp %h", dout_seen[6], 8'h80 | ZBIT); end
  endtask

  task automatic test_channels();
    reg_wr(4'h4, 8'h01); reg_wr(4'h0, 8'h00); reg_wr(4'h1, 8'h01); reg_wr(4'h2, 8'h00);
    idle();
    checks++; if (ra_seen[4] !== 24'h000100) begin errors++; $display("FAIL ch1_ra: got %h exp 000100", ra_seen[4]); end
    reg_wr(4'h4, 8'h00);
    idle();
    checks++; if (ra_seen[4] !== 24'hFFFFFF) begin errors++; $display("FAIL ch0_kept: got %h exp FFFFFF", ra_seen[4]); end
    reg_rd(4'h4);
    checks++; if (dout_seen[6] !== ZBIT) begin errors++; $display("FAIL ch0_ctrl: got %h exp %h", dout_seen[6], ZBIT); end
  endtask

  task automatic test_pending();
    reg_wr(4'h4, 8'h01);
    bus_cycle(DEV | 16'h3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    reg_wr(4'h4, 8'h00);
    checks++; if (ra_seen[3] !== 24'h000101) begin errors++; $display("FAIL pend_ch1_step: got %h exp 000101", ra_seen[3]); end
    checks++; if (ra_seen[8] !== 24'hFFFFFF) begin errors++; $display("FAIL pend_switch: got %h exp FFFFFF", ra_seen[8]); end
    idle();
    checks++; if (ra_seen[4] !== 24'hFFFFFF) begin errors++; $display("FAIL pend_ch0_nostep: got %h exp FFFFFF", ra_seen[4]); end
    reg_wr(4'h4, 8'h01);
    idle();
    checks++; if (ra_seen[4] !== 24'h000101) begin errors++; $display("FAIL pend_ch1_kept: got %h exp 000101", ra_seen[4]); end
  endtask

  task automatic test_counter();
    reg_wr(4'h5, 8'h02); reg_wr(4'h6, 8'h00);
    reg_rd(4'h5);
    checks++; if (dout_seen[6] !== (XFER ? 8'h02 : 8'h00)) begin errors++; $display("FAIL cnt_load: got %h exp %h", dout_seen[6], XFER ? 8'h02 : 8'h00); end
    reg_rd(4'h4);
    checks++; if (dout_seen[6] !== 8'h01) begin errors++; $display("FAIL cnt_ctrl_nz: got %h exp 01", dout_seen[6]); end
    for (int n = 0; n < 3; n++) begin
      bus_cycle(DEV | 16'h3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
      checks++;
      if (ra_seen[6] !== 24'h000101 + 24'(n))
        begin errors++; $display("FAIL b2b_ra n%0d: got %h exp %h", n, ra_seen[6], 24'h000101 + 24'(n)); end
    end
    idle();
    checks++; if (ra_seen[4] !== 24'h000104) begin errors++; $display("FAIL b2b_final: got %h exp 000104", ra_seen[4]); end
    reg_rd(4'h5);
    checks++; if (dout_seen[6] !== 8'h00) begin errors++; $display("FAIL cnt_lo_sat: got %h exp 00", dout_seen[6]); end
    reg_rd(4'h6);
    checks++; if (dout_seen[6] !== 8'h00) begin errors++; $display("FAIL cnt_hi_sat: got %h exp 00", dout_seen[6]); end
    reg_rd(4'h4);
    checks++; if (dout_seen[6] !== (8'h01 | ZBIT)) begin errors++; $display("FAIL cnt_ctrl_zero: got %h exp %h", dout_seen[6], 8'h01 | ZBIT); end
  endtask

  initial begin
    test_reset();
    test_phase();
    test_iorom();
    test_bank();
    test_step_inc();
    test_step_dec();
    test_channels();
    test_pending();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
